// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Issues one registered req/ack bus transfer per memory instruction, holds the
// pipeline with stallreq until the transfer is done, and hands aligned,
// extended load data plus exception flags to MEM/WB.
// Optional access watchdog: define MEM_LSU_TIMEOUT_EN.
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif

module mem_lsu #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [`AluOpBus]  mem_aluop,
  input  logic [31:0]       mem_mem_addr,
  input  logic [31:0]       mem_reg2,
  input  logic [`RegAddrBus] mem_wd,
  input  logic              mem_wreg,
  input  logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_excepttype_i,
  input  logic [31:0]       dbus_rdata,
  input  logic              dbus_ack,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_sel,
  output logic [31:0]       dbus_wdata,
  output logic              stallreq,
  output logic [`RegAddrBus] wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata,
  output logic [31:0]       mem_excepttype_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;

`ifdef MEM_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
`else
  logic               unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  logic        is_load, is_store, is_mem, misaligned, can_issue;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Decode the access: lane enables, replicated store data, alignment.
  always_comb begin : decode
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    sel_c      = '0;
    wdata_c    = '0;
    case (mem_aluop)
      EXE_LB_OP, EXE_LBU_OP: begin
        is_load = 1'b1;
        sel_c   = 4'b0001 << mem_mem_addr[1:0];
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        is_load    = 1'b1;
        sel_c      = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
        misaligned = mem_mem_addr[0];
      end
      EXE_LW_OP: begin
        is_load    = 1'b1;
        sel_c      = 4'b1111;
        misaligned = |mem_mem_addr[1:0];
      end
      EXE_SB_OP: begin
        is_store = 1'b1;
        sel_c    = 4'b0001 << mem_mem_addr[1:0];
        wdata_c  = {4{mem_reg2[7:0]}};
      end
      EXE_SH_OP: begin
        is_store   = 1'b1;
        sel_c      = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{mem_reg2[15:0]}};
        misaligned = mem_mem_addr[0];
      end
      EXE_SW_OP: begin
        is_store   = 1'b1;
        sel_c      = 4'b1111;
        wdata_c    = mem_reg2;
        misaligned = |mem_mem_addr[1:0];
      end
      default: ;
    endcase
    is_mem    = is_load | is_store;
    can_issue = is_mem && !misaligned && (mem_excepttype_i == '0) && !flush;
  end

  // Select and extend the captured load word.
  always_comb begin : load_extend
    byte_sel = rdata_q[{mem_mem_addr[1:0], 3'b000} +: 8];
    half_sel = mem_mem_addr[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (mem_aluop)
      EXE_LB_OP:  load_data = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: load_data = {24'h0, byte_sel};
      EXE_LH_OP:  load_data = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: load_data = {16'h0, half_sel};
      default:    load_data = rdata_q;
    endcase
  end

  // Next-state and next bus-register values.
  always_comb begin : next_state
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (can_issue) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {mem_mem_addr[ADDR_W-1:2], 2'b00};
          sel_d   = sel_c;
          wdata_d = wdata_c;
`ifdef MEM_LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        // An ack coinciding with flush completes the transfer; nothing to drain.
        if (dbus_ack) begin
          req_d   = 1'b0;
          rdata_d = dbus_rdata;
          state_d = flush ? IDLE : DONE;
        end else if (flush) begin
          state_d = DRAIN;
`ifdef MEM_LSU_TIMEOUT_EN
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef MEM_LSU_TIMEOUT_EN
        fault_d = 1'b0;
`endif
      end
      DRAIN: begin
        if (dbus_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
`ifdef MEM_LSU_TIMEOUT_EN
        else if (cnt_q == CNT_MAX) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_LSU_TIMEOUT_EN
      cnt_q   <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
`endif
    end
  end

  // Write-back controls, exception flags and stall request.
  always_comb begin : wb_out
    wb_wd            = mem_wd;
    wb_wreg          = mem_wreg;
    wb_wdata         = mem_wdata;
    mem_excepttype_o = mem_excepttype_i;
    stallreq         = 1'b0;
    if (is_mem && misaligned) begin
      mem_excepttype_o = mem_excepttype_i | (is_load ? 32'h0000_0010 : 32'h0000_0040);
      wb_wreg          = 1'b0;
    end
    if (mem_excepttype_i != '0) wb_wreg = 1'b0;
    case (state_q)
      IDLE:  stallreq = can_issue;
      BUSY:  stallreq = 1'b1;
      DONE: begin
        if (is_load) wb_wdata = load_data;
`ifdef MEM_LSU_TIMEOUT_EN
        if (fault_q) begin
          mem_excepttype_o = mem_excepttype_o | (is_load ? 32'h0000_0020 : 32'h0000_0080);
          wb_wreg          = 1'b0;
        end
`endif
      end
      DRAIN: begin
        wb_wreg  = 1'b0;
        stallreq = can_issue;
      end
      default: ;
    endcase
    if (!rst) stallreq = 1'b0;
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_sel   = sel_q;
  assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and randomized checks of mem_lsu against a
// byte-level memory reference model and a simple bus slave.
module tb_mem_lsu;

  localparam logic [7:0] LB  = 8'hE0;
  localparam logic [7:0] LH  = 8'hE1;
  localparam logic [7:0] LW  = 8'hE3;
  localparam logic [7:0] LBU = 8'hE4;
  localparam logic [7:0] LHU = 8'hE5;
  localparam logic [7:0] SB  = 8'hE8;
  localparam logic [7:0] SH  = 8'hE9;
  localparam logic [7:0] SW  = 8'hEB;
  localparam logic [7:0] ORI = 8'h25;

  logic        clk, rst, flush;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2, mem_wdata, mem_excepttype_i, dbus_rdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg, dbus_ack;
  logic        dbus_req, dbus_we, stallreq, wb_wreg;
  logic [31:0] dbus_addr, dbus_wdata, wb_wdata, mem_excepttype_o;
  logic [3:0]  dbus_sel;
  logic [4:0]  wb_wd;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] ref_mem   [256];
  logic [31:0] slave_mem [256];

  mem_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_excepttype_i(mem_excepttype_i),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .stallreq(stallreq), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .mem_excepttype_o(mem_excepttype_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_ld(input logic [7:0] op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic bit is_st(input logic [7:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic int size_of(input logic [7:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    if (op == LW || op == SW) return 4;
    return 0;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] addr);
    logic [3:0] m;
    m = 4'((32'd1 << size_of(op)) - 32'd1);
    return m << addr[1:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] reg2);
    case (size_of(op))
      1:       return {24'h0, reg2[7:0]} * 32'h0101_0101;
      2:       return {16'h0, reg2[15:0]} * 32'h0001_0001;
      default: return reg2;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * int'(addr[1:0]));
    case (op)
      LB:      return 32'($signed(v[7:0]));
      LBU:     return v & 32'h0000_00FF;
      LH:      return 32'($signed(v[15:0]));
      LHU:     return v & 32'h0000_FFFF;
      default: return word;
    endcase
  endfunction

  task automatic ref_store(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2);
    logic [31:0] w;
    w = ref_mem[addr[9:2]];
    for (int i = 0; i < size_of(op); i++)
      w[8 * (int'(addr[1:0]) + i) +: 8] = reg2[8 * i +: 8];
    ref_mem[addr[9:2]] = w;
  endtask

  task automatic slave_write(input logic [7:0] idx);
    for (int i = 0; i < 4; i++)
      if (dbus_sel[i]) slave_mem[idx][8 * i +: 8] = dbus_wdata[8 * i +: 8];
  endtask

  task automatic park();
    mem_aluop = ORI; mem_excepttype_i = '0; flush = 1'b0; dbus_ack = 1'b0;
  endtask

  // One instruction through the MEM stage, with the bench acting as EX/MEM and bus slave.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] wdata, input logic wreg, input logic [31:0] exc,
                        input logic fl, input int unsigned ack_wait, input logic stray_ack);
    bit ld, st, mis, issue;
    int sz;
    int unsigned stall_cycles;
    logic [31:0] exp_exc;
    logic [7:0]  idx;
    logic [4:0]  wd;
    wd  = 5'($urandom);
    ld  = is_ld(op);
    st  = is_st(op);
    sz  = size_of(op);
    mis = (sz > 1) && ((int'(addr[1:0]) % sz) != 0);
    issue = (ld || st) && !mis && (exc == 0) && !fl;
    exp_exc = exc | (mis ? (ld ? 32'h10 : 32'h40) : 32'h0);
    idx = addr[9:2];
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2; mem_wd = wd;
    mem_wreg = wreg; mem_wdata = wdata; mem_excepttype_i = exc; flush = fl;
    @(negedge clk);
    check("wb_wd", 32'(wb_wd), 32'(wd));
    check("excepttype", mem_excepttype_o, exp_exc);
    if (!issue) begin
      check("stall_noissue", 32'(stallreq), 32'd0);
      check("wreg_noissue", 32'(wb_wreg), (mis || exc != 0) ? 32'd0 : 32'(wreg));
      check("wdata_noissue", wb_wdata, wdata);
      dbus_ack = stray_ack;
      @(posedge clk); #1;
      dbus_ack = 1'b0; flush = 1'b0;
      check("req_noissue", 32'(dbus_req), 32'd0);
      return;
    end
    check("stall_issue", 32'(stallreq), 32'd1);
    check("req_preissue", 32'(dbus_req), 32'd0);
    stall_cycles = 1;
    @(posedge clk); #1;
    for (int unsigned n = 0; n <= ack_wait; n++) begin
      @(negedge clk);
      stall_cycles += 32'(stallreq);
      check("busy_req", 32'(dbus_req), 32'd1);
      check("busy_we", 32'(dbus_we), 32'(st));
      check("busy_addr", dbus_addr, {addr[31:2], 2'b00});
      check("busy_sel", 32'(dbus_sel), 32'(exp_sel(op, addr)));
      if (st) check("busy_wdata", dbus_wdata, exp_wdata(op, reg2));
      if (n == ack_wait) begin
        dbus_ack = 1'b1;
        if (st) begin
          slave_write(idx);
          dbus_rdata = $urandom;
        end else begin
          dbus_rdata = slave_mem[idx];
        end
      end
      @(posedge clk); #1;
      dbus_ack = 1'b0; dbus_rdata = $urandom;
    end
    @(negedge clk);
    stall_cycles += 32'(stallreq);
    check("stall_cycles", stall_cycles, ack_wait + 2);
    check("done_req", 32'(dbus_req), 32'd0);
    check("done_wreg", 32'(wb_wreg), 32'(wreg));
    check("done_wdata", wb_wdata, ld ? load_value(op, addr, ref_mem[idx]) : wdata);
    if (st) ref_store(op, addr, reg2);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0]  ops [9];
    logic [7:0]  op;
    logic [31:0] a, w;
    int sz;
    int unsigned req_cycles;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ORI};
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      ref_mem[i] = w; slave_mem[i] = w;
    end

    // Reset state
    rst = 1'b0; flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
    mem_aluop = ORI; mem_mem_addr = 32'h104; mem_reg2 = '0; mem_wd = 5'd7;
    mem_wreg = 1'b1; mem_wdata = 32'h1357_9BDF; mem_excepttype_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_we", 32'(dbus_we), 32'd0);
    check("rst_addr", dbus_addr, 32'd0);
    check("rst_sel", 32'(dbus_sel), 32'd0);
    check("rst_wdata", dbus_wdata, 32'd0);
    check("rst_stall", 32'(stallreq), 32'd0);
    check("rst_wreg", 32'(wb_wreg), 32'd1);
    check("rst_wbdata", wb_wdata, 32'h1357_9BDF);
    check("rst_wd", 32'(wb_wd), 32'd7);
    check("rst_exc", mem_excepttype_o, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // LW with three wait cycles
    ref_mem[8'h40] = 32'hDEAD_BEEF; slave_mem[8'h40] = 32'hDEAD_BEEF;
    run_op(LW, 32'h100, 32'h0, 32'h1234, 1'b1, 32'h0, 1'b0, 3, 1'b0);
    // byte loads from the top lane
    ref_mem[8'h40] = 32'h8011_2233; slave_mem[8'h40] = 32'h8011_2233;
    run_op(LB, 32'h103, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 0, 1'b0);
    run_op(LBU, 32'h103, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    // halfword store to upper lanes
    run_op(SH, 32'h202, 32'h0000_ABCD, 32'h5555, 1'b1, 32'h0, 1'b0, 0, 1'b0);
    run_op(LW, 32'h200, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 2, 1'b0);
    // misaligned halfword load, stray ack ignored
    run_op(LH, 32'h301, 32'h0, 32'h77, 1'b1, 32'h0, 1'b0, 0, 1'b1);
    // upstream exception blocks the access
    run_op(SW, 32'h300, 32'h0, 32'h88, 1'b1, 32'h4, 1'b0, 0, 1'b0);

    // flush in the second BUSY cycle, then a new load waiting out the drain
    mem_aluop = LW; mem_mem_addr = 32'h108; mem_wreg = 1'b1; mem_excepttype_i = '0; flush = 1'b0;
    @(negedge clk); check("fl_stall_issue", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); check("fl_busy1_req", 32'(dbus_req), 32'd1);
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk); check("fl_busy2_req", 32'(dbus_req), 32'd1);
    @(posedge clk); #1; flush = 1'b0; mem_aluop = ORI; mem_wreg = 1'b1;
    @(negedge clk);
    check("drain_req", 32'(dbus_req), 32'd1);
    check("drain_stall", 32'(stallreq), 32'd0);
    check("drain_wreg", 32'(wb_wreg), 32'd0);
    @(posedge clk); #1; mem_aluop = LW; mem_mem_addr = 32'h10C;
    @(negedge clk);
    check("drain_newop_stall", 32'(stallreq), 32'd1);
    check("drain2_req", 32'(dbus_req), 32'd1);
    dbus_ack = 1'b1; dbus_rdata = $urandom;
    @(posedge clk); #1; dbus_ack = 1'b0;
    @(negedge clk);
    check("postdrain_req", 32'(dbus_req), 32'd0);
    check("postdrain_stall", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("reissue_addr", dbus_addr, 32'h10C);
    check("reissue_req", 32'(dbus_req), 32'd1);
    dbus_ack = 1'b1; dbus_rdata = slave_mem[8'h43];
    @(posedge clk); #1; dbus_ack = 1'b0;
    @(negedge clk);
    check("reissue_stall", 32'(stallreq), 32'd0);
    check("reissue_wdata", wb_wdata, ref_mem[8'h43]);
    check("reissue_wreg", 32'(wb_wreg), 32'd1);
    @(posedge clk); #1; park();

    // asynchronous reset in the middle of a store
    mem_aluop = SW; mem_mem_addr = 32'h110; mem_reg2 = 32'hCAFE_F00D;
    @(negedge clk); check("rstb_stall", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); check("rstb_req", 32'(dbus_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstb_req_async", 32'(dbus_req), 32'd0);
    check("rstb_stall_async", 32'(stallreq), 32'd0);
    check("rstb_sel_async", 32'(dbus_sel), 32'd0);
    park();
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); check("rstb_idle_req", 32'(dbus_req), 32'd0);
    @(posedge clk); #1;

`ifdef MEM_LSU_TIMEOUT_EN
    // store with no ack times out
    mem_aluop = SW; mem_mem_addr = 32'h114; mem_reg2 = 32'h1111_2222; mem_wreg = 1'b1;
    @(negedge clk); check("to_stall_issue", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    req_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!dbus_req) break;
      req_cycles++;
      @(posedge clk); #1;
    end
    check("to_req_cycles", req_cycles, 32'd4);
    check("to_stall", 32'(stallreq), 32'd0);
    check("to_exc", mem_excepttype_o, 32'h80);
    check("to_wreg", 32'(wb_wreg), 32'd0);
    @(posedge clk); #1; park();
    @(posedge clk); #1;
`endif

    // randomized traffic
    for (int t = 0; t < 200; t++) begin
      op = ops[$urandom_range(0, 8)];
      sz = size_of(op);
      a  = {22'h0, 8'($urandom), 2'($urandom)};
      if (sz > 1 && $urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~2'(sz - 1);
      run_op(op, a, $urandom, $urandom, 1'($urandom),
             ($urandom_range(0, 9) == 0) ? (32'h1 << $urandom_range(0, 3)) : 32'h0,
             1'($urandom_range(0, 15) == 0), $urandom_range(0, 3), 1'($urandom));
    end
    park();
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit. Consumes the EX/MEM register's mem_* outputs and drives the data bus using a req/ack handshake.
- Returns aligned, sign/zero-extended load data, write-back controls and exception flags to the MEM/WB register.
- Raises stallreq to the stall controller while a bus transfer is outstanding.

Parameters:
- ADDR_W, 32, data-bus byte-address width.
- TIMEOUT_CYCLES, 16, watchdog limit for an outstanding access (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  pipeline flush from ctrl.
- mem_aluop  in  `AluOpBus  operation; only EXE_LB/LH/LW/LBU/LHU/SB/SH/SW_OP access memory.
- mem_mem_addr  in  32  effective byte address.
- mem_reg2  in  32  store data.
- mem_wd  in  `RegAddrBus  destination register.
- mem_wreg  in  1  write-back enable.
- mem_wdata  in  32  ALU result, used for non-load instructions.
- mem_excepttype_i  in  32  exception bits from upstream.
- dbus_rdata  in  32  read data, valid when dbus_ack=1.
- dbus_ack  in  1  single-cycle completion strobe.
- dbus_req  out  1  access request; registered.
- dbus_we  out  1  1 = write; registered.
- dbus_addr  out  ADDR_W  word-aligned address {addr[31:2],2'b00}; registered.
- dbus_sel  out  4  byte-lane enables; registered.
- dbus_wdata  out  32  lane-replicated store data; registered.
- stallreq  out  1  request to stall PC..EX/MEM.
- wb_wd  out  `RegAddrBus  to MEM/WB.
- wb_wreg  out  1  to MEM/WB.
- wb_wdata  out  32  to MEM/WB.
- mem_excepttype_o  out  32  exception bits to MEM/WB and ctrl.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - dbus_req=0, dbus_we=0, dbus_addr=0, dbus_sel=0, dbus_wdata=0.
  - Load capture register=0.
  - Combinational outputs are then: stallreq=0, wb_* = mem_* passthrough, mem_excepttype_o = mem_excepttype_i.
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE, non-memory aluop: wb_* = mem_* passthrough, stallreq=0, no bus activity.
- IDLE, memory aluop, aligned, mem_excepttype_i==0, flush=0:
  - stallreq=1 (combinational).
  - Next edge: load dbus_* registers, dbus_req=1, go to BUSY.
- Misalignment: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
  - No bus access.
  - mem_excepttype_o = mem_excepttype_i | bit4 (load) or bit6 (store).
  - wb_wreg=0, stallreq=0.
- Upstream exception (mem_excepttype_i!=0): no bus access; wb_wreg=0.
- BUSY:
  - stallreq=1; dbus_req and all dbus_* held stable until dbus_ack.
  - On ack: capture dbus_rdata, drop dbus_req the same edge, go to DONE.
  - flush while BUSY: go to DRAIN (the bus is never abandoned).
- DONE:
  - stallreq=0; wb_wdata = extended load data (stores: wb_wdata = mem_wdata).
  - Next edge: the pipeline advances, go to IDLE.
  - Total latency is 2 + ack-wait cycles; with ack on the first BUSY cycle, stallreq is high for exactly 2 cycles.
- DRAIN:
  - stallreq=0, wb_wreg=0.
  - Keep dbus_req=1 until ack; discard the data; go to IDLE.
  - A new memory op seen in DRAIN holds stallreq=1 until IDLE.
- Lanes:
  - SB: sel = 4'b0001<<addr[1:0], wdata = {4{reg2[7:0]}}.
  - SH: sel = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{reg2[15:0]}}.
  - SW: sel = 4'b1111.
  - Loads: sel uses the same rule; dbus_we=0.
- Load extension:
  - LB/LH sign-extend the byte/half selected by addr[1:0].
  - LBU/LHU zero-extend it.
  - LW uses the full word.
- flush in IDLE or DONE: no new request is issued; state returns to or stays in IDLE.
- A dbus_ack seen outside BUSY/DRAIN is ignored.

Optional Feature:
- Macro MEM_LSU_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to BUSY/DRAIN and increments each waiting cycle.
  - On reaching TIMEOUT_CYCLES without ack: dbus_req drops, state goes to DONE.
  - mem_excepttype_o sets bit5 (load) or bit7 (store) access fault; wb_wreg=0.
  - A DRAIN timeout returns straight to IDLE.
- When undefined: no counter; the unit waits indefinitely for ack.

Test Plan:
- LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> dbus_addr=0x100, sel=1111, stallreq high 5 cycles, wb_wdata=0xDEADBEEF, wb_wreg=1.
- LB addr 0x103, rdata 0x80112233 -> sel=1000, wb_wdata=0xFFFFFF80. LBU, same inputs -> wb_wdata=0x00000080.
- SH addr 0x202, reg2=0x0000ABCD -> dbus_we=1, sel=1100, dbus_wdata=0xABCDABCD, wb_wreg unchanged.
- LH addr 0x301 -> no dbus_req, mem_excepttype_o bit4=1, wb_wreg=0, stallreq=0.
- LW issued, flush in 2nd BUSY cycle, ack 2 cycles later -> dbus_req held until ack, then IDLE, wb_wreg=0. rst pulled low mid-BUSY -> dbus_req=0 immediately.
- With MEM_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, SW with no ack -> dbus_req drops after 4 cycles, bit7 set, stallreq released.
